// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM states, AXI response codes and round-robin helper
package axi_arb_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; lowest requester at or after i_ptr wins
module rr_arbiter #(
   parameter int NUM_MST = 2,
   parameter int IDX_W   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
)(
   input  logic [NUM_MST-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_found
);
   // scan farthest offset first so the nearest requester overwrites
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int k = NUM_MST - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % NUM_MST]) begin
            o_found = 1'b1;
            o_idx   = IDX_W'((int'(i_ptr) + k) % NUM_MST);
         end
      end
   end
endmodule

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin, transaction-locked sharing of one AXI write port
module axi_wr_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_MST = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int ID_W    = 4,
   parameter int LEN_W   = 8
)(
   input  logic                            aclk,
   input  logic                            arst_n,
   input  logic [NUM_MST-1:0]              s_awvalid,
   output logic [NUM_MST-1:0]              s_awready,
   input  logic [NUM_MST*ADDR_W-1:0]       s_awaddr,
   input  logic [NUM_MST*ID_W-1:0]         s_awid,
   input  logic [NUM_MST*LEN_W-1:0]        s_awlen,
   input  logic [NUM_MST-1:0]              s_wvalid,
   output logic [NUM_MST-1:0]              s_wready,
   input  logic [NUM_MST*DATA_W-1:0]       s_wdata,
   input  logic [NUM_MST*(DATA_W/8)-1:0]   s_wstrb,
   input  logic [NUM_MST-1:0]              s_wlast,
   output logic [NUM_MST-1:0]              s_bvalid,
   input  logic [NUM_MST-1:0]              s_bready,
   output logic [1:0]                      s_bresp,
   output logic [ID_W-1:0]                 s_bid,
   output logic                            m_awvalid,
   input  logic                            m_awready,
   output logic [ADDR_W-1:0]               m_awaddr,
   output logic [ID_W-1:0]                 m_awid,
   output logic [LEN_W-1:0]                m_awlen,
   output logic                            m_wvalid,
   input  logic                            m_wready,
   output logic [DATA_W-1:0]               m_wdata,
   output logic [DATA_W/8-1:0]             m_wstrb,
   output logic                            m_wlast,
   input  logic                            m_bvalid,
   output logic                            m_bready,
   input  logic [1:0]                      m_bresp,
   input  logic [ID_W-1:0]                 m_bid,
   output logic [$clog2(NUM_MST)-1:0]      grant_idx,
   output logic                            busy,
   output logic                            err_wlast
);
   localparam int IDX_W  = $clog2(NUM_MST);
   localparam int STRB_W = DATA_W / 8;
   state_t             r_state, w_next;
   logic [IDX_W-1:0]   r_rr_ptr, r_grant, w_win;
   logic [ADDR_W-1:0]  r_awaddr;
   logic [ID_W-1:0]    r_awid;
   logic [LEN_W-1:0]   r_awlen, r_beat_cnt;
   logic               r_err;
   logic               w_found, w_aw_hs, w_w_hs, w_b_hs, w_last_beat;
   rr_arbiter #(.NUM_MST(NUM_MST), .IDX_W(IDX_W)) u_rr (
      .i_req   (s_awvalid),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_win),
      .o_found (w_found)
   );
   assign w_aw_hs     = (r_state == ST_AW) && m_awready;
   assign w_w_hs      = (r_state == ST_W) && s_wvalid[r_grant] && m_wready;
   assign w_b_hs      = (r_state == ST_B) && m_bvalid && s_bready[r_grant];
   // an exhausted beat count terminates the burst even without upstream wlast
   assign w_last_beat = s_wlast[r_grant] || (r_beat_cnt == '0);
   assign m_awaddr    = r_awaddr;
   assign m_awid      = r_awid;
   assign m_awlen     = r_awlen;
   assign grant_idx   = r_grant;
   assign busy        = r_state != ST_IDLE;
   assign err_wlast   = r_err;
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end
   always_comb begin
      w_next    = r_state;
      s_awready = '0;
      s_wready  = '0;
      s_bvalid  = '0;
      if (r_state == ST_IDLE && w_found) w_next = ST_AW;
      if (w_aw_hs) w_next = ST_W;
      if (w_w_hs && w_last_beat) w_next = ST_B;
      if (w_b_hs) w_next = ST_IDLE;
      m_awvalid          = r_state == ST_AW;
      s_awready[r_grant] = w_aw_hs;
      m_wvalid           = (r_state == ST_W) && s_wvalid[r_grant];
      m_wdata            = (r_state == ST_W) ? s_wdata[r_grant*DATA_W +: DATA_W] : '0;
      m_wstrb            = (r_state == ST_W) ? s_wstrb[r_grant*STRB_W +: STRB_W] : '0;
      m_wlast            = (r_state == ST_W) && w_last_beat;
      s_wready[r_grant]  = (r_state == ST_W) && m_wready;
      s_bvalid[r_grant]  = (r_state == ST_B) && m_bvalid;
      m_bready           = (r_state == ST_B) && s_bready[r_grant];
      s_bresp            = (r_state == ST_B) ? m_bresp : RESP_OKAY;
      s_bid              = (r_state == ST_B) ? m_bid : '0;
   end
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         r_rr_ptr   <= '0;
         r_grant    <= '0;
         r_awaddr   <= '0;
         r_awid     <= '0;
         r_awlen    <= '0;
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && w_found) begin
            r_grant  <= w_win;
            r_rr_ptr <= IDX_W'(rr_next(int'(w_win), NUM_MST));
            r_awaddr <= s_awaddr[w_win*ADDR_W +: ADDR_W];
            r_awid   <= s_awid[w_win*ID_W +: ID_W];
            r_awlen  <= s_awlen[w_win*LEN_W +: LEN_W];
         end
         if (w_aw_hs) r_beat_cnt <= r_awlen;
         if (w_w_hs) begin
            r_beat_cnt <= (r_beat_cnt == '0) ? '0 : r_beat_cnt - 1'b1;
            if (s_wlast[r_grant] != (r_beat_cnt == '0)) r_err <= 1'b1;
         end
      end
   end
endmodule
